// File: rtl/joypad_conditioner.sv
// Joypad front-end: synchronise and debounce five buttons, then raise sticky
// press events (with auto-repeat) and a level interrupt while any is pending.
module joypad_conditioner #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] state,
    output logic [4:0] events,
    input  logic [4:0] events_clr,
    output logic       irq
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam bit REPEAT_ON = (REPEAT_DELAY != 0);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = REPEAT_ON ? TW'(REPEAT_DELAY - 1) : '0;
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    logic [4:0]    logical;
    logic [4:0]    sync_a;
    logic [4:0]    sync;
    logic [CW-1:0] cnt [5];
    logic [4:0]    mismatch;
    logic [4:0]    flip;
    logic [4:0]    state_nxt;
    logic [4:0]    state_q;
    logic [4:0]    press;
    logic [TW-1:0] timer;
    logic          phase;
    logic          running;
    logic          tick;

    assign logical = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync   <= '0;
        end else begin
            sync_a <= logical;
            sync   <= sync_a;
        end
    end

    // A bit flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        flip     = '0;
        mismatch = sync ^ state;
        for (int i = 0; i < 5; i++) begin
            flip[i] = mismatch[i] && (cnt[i] == DEB_LAST);
        end
        state_nxt = state ^ flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
            state <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!mismatch[i] || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            state <= state_nxt;
        end
    end

    // The repeat timer only runs across edges where a non-zero state holds.
    assign press   = state & ~state_q;
    assign running = (state_nxt == state) && (state != '0);
    assign tick    = REPEAT_ON && running && (timer == (phase ? RATE_LAST : DELAY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            timer   <= '0;
            phase   <= 1'b0;
            events  <= '0;
        end else begin
            state_q <= state;
            if (!running || !REPEAT_ON) begin
                timer <= '0;
                phase <= 1'b0;
            end else if (tick) begin
                timer <= '0;
                phase <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
            events <= (events & ~events_clr) | press | (tick ? state : 5'b0);
        end
    end

    assign irq = |events;

endmodule

// File: doc/joypad_conditioner.md
Name: joypad_conditioner

Overview:
Front-end for the five joypad buttons. It sits between the board pins and the SoC's 5-bit joypad read port, and is instantiated next to the top level.
- Synchronises and debounces the raw inputs, then presents a clean level vector.
- Produces sticky press events with auto-repeat, which firmware clears per bit.
- Raises a level interrupt while any event is pending.

Parameters:
- ACTIVE_LOW, 1, raw pins read 0 when pressed; inverted before synchronisation.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before `state` flips (5 ms at 50 MHz); legal range ≥1.
- REPEAT_DELAY, 25000000, cycles of unchanged non-zero `state` before the first repeat; 0 disables auto-repeat.
- REPEAT_RATE, 5000000, cycles between subsequent repeats; legal range ≥1.

Ports:
- clk, input, 1, system clock (CPU clock domain).
- rst_n, input, 1, reset, asynchronous and active-low.
- btn_raw, input, 5, asynchronous button pins.
- state, output, 5, debounced level, 1 = pressed; drives the SoC joypad read port.
- events, output, 5, sticky event flags, one per button.
- events_clr, input, 5, write-1-to-clear strobe for `events`, one cycle wide.
- irq, output, 1, OR of all `events` bits.

Behaviour:
- Reset (asynchronous, rst_n=0): sync flops, `state`, `events`, debounce counters and repeat timer all go to 0 immediately. `irq` is 0.
- Input stage:
  - logical = ACTIVE_LOW ? ~btn_raw : btn_raw.
  - Two-flop synchroniser per bit, giving `sync`.
- Debounce, per bit i, independent:
  - cnt[i] has width clog2(DEBOUNCE_CYCLES+1).
  - If sync[i]==state[i], cnt[i] is cleared.
  - Otherwise cnt[i] increments. On the cycle cnt[i]==DEBOUNCE_CYCLES-1 with a mismatch still present, state[i] toggles and cnt[i] clears.
  - A single matching cycle restarts the count, so bounce shorter than DEBOUNCE_CYCLES never propagates.
  - Latency from a clean pin edge to the `state` change is exactly DEBOUNCE_CYCLES+2 clk.
- Press detect: press[i] = state[i] & ~state_q[i], a one-cycle pulse on the cycle after `state` rises. Releases generate no event.
- Auto-repeat (one shared timer):
  - The timer and the phase flag reset to 0 whenever `state` changes or `state`==0.
  - Otherwise the timer counts up.
  - Phase 0: when the timer reaches REPEAT_DELAY-1, a repeat tick fires, the timer clears and phase goes to 1.
  - Phase 1: a tick fires every REPEAT_RATE cycles.
  - A tick sets events |= state.
  - If REPEAT_DELAY==0, no ticks are ever produced.
  - Pressing or releasing any button restarts the delay phase.
- Events register, per bit: next = (events & ~events_clr) | press | (tick ? state : 0).
  - Set wins over clear in the same cycle.
  - A clear of a bit that is not set has no effect.
- irq = |events, from registered state; no extra latency beyond `events`.
- Counter widths must hold their parameter maximum. The timer never wraps, because it clears on every tick.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, ACTIVE_LOW=1):
- Reset: hold rst_n=0 with btn_raw=5'b00000 (all pressed) → state=0, events=0, irq=0 throughout; after release, state=5'b11111 exactly 6 cycles later.
- Clean press: btn_raw 5'b11111→5'b11110 held → state=5'b00001 exactly 6 cycles after the pin edge; events=5'b00001 and irq=1 one cycle later.
- Bounce: toggle btn_raw[2] every 3 cycles for 30 cycles → state[2] stays 0 and events stays 0; then hold low → state[2]=1 after 6 cycles.
- Clear and collision:
  - events_clr=5'b00001 with no press → events[0]=0 and irq=0 next cycle.
  - events_clr[3] pulsed on the same cycle as press[3] → events[3] stays 1.
- Auto-repeat: hold button 0 and clear after each event → events[0] re-sets 20 cycles after state rises, then every 8 cycles. Pressing button 1 mid-repeat restarts the 20-cycle delay, and the next tick sets events=5'b00011.
- Reset mid-debounce: assert rst_n 2 cycles before state would rise → all outputs 0 immediately; after release with the pin still held, the full 6-cycle latency applies again.
